register_rename_map: RTL



---
 rtl/register_rename_map.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/register_rename_map.sv
`default_nettype none
// ============================================================================
// Module      : register_rename_map
// Description : Rename-stage logical-to-physical register map with a circular
//               physical free list. Renames up to one instruction per cycle,
//               hands superseded {physical, logical} pairings to the active
//               list, accepts committed registers back, and applies walk-back
//               pairings during flush recovery.
//
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               rename_valid/ready       - rename handshake
//               src_a, src_b, dst, dst_wr- logical operands of the instruction
//               out_valid, phys_*        - renamed operands (1-cycle latency)
//               add_mapping, prev_*      - superseded pairing to active list
//               free_valid, free_phys    - commit returns a physical register
//               flush, restore_*, flush_done - recovery walk-back interface
//               busy                     - recovery in progress
//               free_count, fl_overflow  - free-list occupancy / sticky error
//
// Revision    : 1.0 - initial release
// ============================================================================
module register_rename_map #(
    parameter int NUM_LOGICAL  = 32,
    parameter int NUM_PHYSICAL = 64,
    parameter int LOG_W        = $clog2(NUM_LOGICAL),
    parameter int PHYS_W       = $clog2(NUM_PHYSICAL),
    parameter int FL_DEPTH     = NUM_PHYSICAL - NUM_LOGICAL,
    parameter int FL_PTR_W     = $clog2(FL_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    // rename request
    input  logic                rename_valid,
    output logic                rename_ready,
    input  logic [LOG_W-1:0]    src_a,
    input  logic [LOG_W-1:0]    src_b,
    input  logic [LOG_W-1:0]    dst,
    input  logic                dst_wr,
    // rename result
    output logic                out_valid,
    output logic [PHYS_W-1:0]   phys_src_a,
    output logic [PHYS_W-1:0]   phys_src_b,
    output logic [PHYS_W-1:0]   phys_dst,
    // pairing toward the active list
    output logic                add_mapping,
    output logic [PHYS_W-1:0]   prev_physical_reg,
    output logic [LOG_W-1:0]    prev_logical_reg,
    // commit release
    input  logic                free_valid,
    input  logic [PHYS_W-1:0]   free_phys,
    // recovery
    input  logic                flush,
    input  logic                restore_valid,
    input  logic [LOG_W-1:0]    restore_logical,
    input  logic [PHYS_W-1:0]   restore_physical,
    input  logic                flush_done,
    output logic                busy,
    // status
    output logic [FL_PTR_W:0]   free_count,
    output logic                fl_overflow
);

    localparam logic [FL_PTR_W:0] c_FL_FULL = (FL_PTR_W+1)'(FL_DEPTH);
    localparam logic [FL_PTR_W:0] c_ONE     = (FL_PTR_W+1)'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [PHYS_W-1:0]     r_map [NUM_LOGICAL];
    logic [PHYS_W-1:0]     r_fl  [FL_DEPTH];
    logic [FL_PTR_W-1:0]   r_head;
    logic [FL_PTR_W-1:0]   r_tail;
    logic [FL_PTR_W:0]     r_count;
    logic                  r_ovf;

    logic                  r_out_valid;
    logic [PHYS_W-1:0]     r_phys_src_a;
    logic [PHYS_W-1:0]     r_phys_src_b;
    logic [PHYS_W-1:0]     r_phys_dst;
    logic                  r_add_mapping;
    logic [PHYS_W-1:0]     r_prev_phys;
    logic [LOG_W-1:0]      r_prev_log;

    logic                  w_needs_alloc;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_pop;
    logic [PHYS_W-1:0]     w_fl_head;
    logic                  w_restore_push;
    logic [PHYS_W-1:0]     w_restore_val;
    logic                  w_push0_ok;
    logic                  w_push1_ok;
    logic [FL_PTR_W:0]     w_cnt_after0;
    logic [FL_PTR_W-1:0]   w_tail1;
    logic [FL_PTR_W:0]     w_count_nxt;
    logic                  w_drop;

    // ------------------------------------------------------------------
    // Handshake. flush blocks acceptance in its own cycle so a rename can
    // never race with the start of recovery.
    // ------------------------------------------------------------------
    assign w_needs_alloc = dst_wr && (dst != '0);
    assign w_ready       = (r_state == ST_RUN) && !flush &&
                           ((r_count != '0) || !w_needs_alloc);
    assign w_accept      = rename_valid && w_ready;
    assign w_pop         = w_accept && w_needs_alloc;
    assign w_fl_head     = r_fl[r_head];

    // ------------------------------------------------------------------
    // Free-list pushes: restore first, then commit. Each push is judged
    // against the occupancy including any earlier push of this cycle; a
    // push that would exceed capacity is dropped and flagged.
    // ------------------------------------------------------------------
    assign w_restore_push = (r_state == ST_FLUSH) && restore_valid &&
                            (restore_logical != '0);
    assign w_restore_val  = r_map[restore_logical];
    assign w_push0_ok     = w_restore_push && (r_count != c_FL_FULL);
    assign w_cnt_after0   = w_push0_ok ? (r_count + c_ONE) : r_count;
    assign w_push1_ok     = free_valid && (w_cnt_after0 != c_FL_FULL);
    assign w_tail1        = w_push0_ok ? (r_tail + FL_PTR_W'(1)) : r_tail;
    assign w_drop         = (w_restore_push && !w_push0_ok) ||
                            (free_valid && !w_push1_ok);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push0_ok) begin
            w_count_nxt = w_count_nxt + c_ONE;
        end
        if (w_push1_ok) begin
            w_count_nxt = w_count_nxt + c_ONE;
        end
        if (w_pop) begin
            w_count_nxt = w_count_nxt - c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Recovery state machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Map, free list and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOGICAL; i++) begin
                r_map[i] <= PHYS_W'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_fl[i] <= PHYS_W'(NUM_LOGICAL + i);
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= c_FL_FULL;
            r_ovf         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_phys_src_a  <= '0;
            r_phys_src_b  <= '0;
            r_phys_dst    <= '0;
            r_add_mapping <= 1'b0;
            r_prev_phys   <= '0;
            r_prev_log    <= '0;
        end else begin
            if (w_push0_ok) begin
                r_fl[r_tail] <= w_restore_val;
            end
            if (w_push1_ok) begin
                r_fl[w_tail1] <= free_phys;
            end
            r_tail  <= w_push1_ok ? (w_tail1 + FL_PTR_W'(1)) : w_tail1;
            if (w_pop) begin
                r_head <= r_head + FL_PTR_W'(1);
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            // Rename writes only happen in RUN and restores only in FLUSH,
            // so the two map writes never collide. Logical 0 is excluded
            // from both, keeping map[0] pinned to physical 0.
            if (w_pop) begin
                r_map[dst] <= w_fl_head;
            end
            if (w_restore_push) begin
                r_map[restore_logical] <= restore_physical;
            end

            // Sources sample the map before this cycle's destination write,
            // so src == dst observes the old mapping.
            r_out_valid   <= w_accept;
            r_phys_src_a  <= w_accept ? r_map[src_a] : '0;
            r_phys_src_b  <= w_accept ? r_map[src_b] : '0;
            r_phys_dst    <= w_pop ? w_fl_head : '0;
            r_add_mapping <= w_pop;
            r_prev_phys   <= w_pop ? r_map[dst] : '0;
            r_prev_log    <= w_pop ? dst : '0;
        end
    end

    assign rename_ready      = w_ready;
    assign out_valid         = r_out_valid;
    assign phys_src_a        = r_phys_src_a;
    assign phys_src_b        = r_phys_src_b;
    assign phys_dst          = r_phys_dst;
    assign add_mapping       = r_add_mapping;
    assign prev_physical_reg = r_prev_phys;
    assign prev_logical_reg  = r_prev_log;
    assign busy              = (r_state == ST_FLUSH);
    assign free_count        = r_count;
    assign fl_overflow       = r_ovf;

endmodule
`default_nettype wire
